// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-road traffic light controller with pedestrian walk phase
module traffic_ctrl #(
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int MIN_GREEN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_state,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending
);

    // Zero-length phases are stretched to one cycle; minimum green never exceeds green.
    localparam int G_EFF   = (GREEN_CYC  < 1) ? 1 : GREEN_CYC;
    localparam int Y_EFF   = (YELLOW_CYC < 1) ? 1 : YELLOW_CYC;
    localparam int R_EFF   = (ALLRED_CYC < 1) ? 1 : ALLRED_CYC;
    localparam int W_EFF   = (WALK_CYC   < 1) ? 1 : WALK_CYC;
    localparam int MIN_RAW = (MIN_GREEN  < 1) ? 1 : MIN_GREEN;
    localparam int MIN_EFF = (MIN_RAW > G_EFF) ? G_EFF : MIN_RAW;

    localparam logic [15:0] G_LD  = 16'(G_EFF - 1);
    localparam logic [15:0] Y_LD  = 16'(Y_EFF - 1);
    localparam logic [15:0] R_LD  = 16'(R_EFF - 1);
    localparam logic [15:0] W_LD  = 16'(W_EFF - 1);
    // Counter value seen on the last cycle of a green cut short to MIN_EFF cycles.
    localparam logic [15:0] G_THR = 16'(G_EFF - MIN_EFF);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        RED2 = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        RED1 = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        WALK = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ped_q, ped_d;
    logic        btn_q, btn_d;

    logic        expired;
    logic        green_cut;
    logic        rise;

    assign expired   = (cnt_q == 16'd0);
    assign green_cut = ped_q && (cnt_q == G_THR);
    assign rise      = button_state && !btn_q;

    function automatic logic [15:0] load_val(input state_t s);
        case (s)
            NS_G, EW_G: load_val = G_LD;
            NS_Y, EW_Y: load_val = Y_LD;
            WALK:       load_val = W_LD;
            default:    load_val = R_LD;
        endcase
    endfunction

    // Next phase, phase counter reload, and pedestrian request bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        btn_d   = button_state;
        ped_d   = ped_q;

        case (state_q)
            RED2:    if (expired) state_d = ped_q ? WALK : NS_G;
            NS_G:    if (expired || green_cut) state_d = NS_Y;
            NS_Y:    if (expired) state_d = RED1;
            RED1:    if (expired) state_d = EW_G;
            EW_G:    if (expired || green_cut) state_d = EW_Y;
            EW_Y:    if (expired) state_d = RED2;
            WALK:    if (expired) state_d = NS_G;
            default: state_d = RED2;
        endcase

        if (state_d != state_q) begin
            cnt_d = load_val(state_d);
        end

        // Presses during the walk are dropped; entering the walk wins over a new press.
        if (rise && (state_q != WALK)) begin
            ped_d = 1'b1;
        end
        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_d = 1'b0;
        end
    end

    // State, counter and request registers; reset lands in all-red clearance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RED2;
            cnt_q   <= R_LD;
            ped_q   <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
            btn_q   <= btn_d;
        end
    end

    // Lamp decode from the current phase only.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        walk     = 1'b0;
        case (state_q)
            NS_G:    ns_light = LAMP_GRN;
            NS_Y:    ns_light = LAMP_YEL;
            EW_G:    ew_light = LAMP_GRN;
            EW_Y:    ew_light = LAMP_YEL;
            WALK:    walk     = 1'b1;
            default: ;
        endcase
    end

    assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - scoreboard bench for traffic_ctrl with directed phase traces
module tb_traffic_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_state;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;

    traffic_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .button_state (button_state),
        .ns_light     (ns_light),
        .ew_light     (ew_light),
        .walk         (walk),
        .ped_pending  (ped_pending)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic [7:0] exp_q[$];
    bit         btn_v[0:127];
    bit         rst_v[0:127];
    bit         mon_en = 1'b0;
    string      scn = "";
    int         tests = 0;
    int         fails = 0;
    int         step = 0;
    logic [7:0] mon_e;
    logic [7:0] mon_a;

    // Each sample point pops one expected {ns, ew, walk, ped} word.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_a = {ns_light, ew_light, walk, ped_pending};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s step%0d no expectation queued, actual=%b", scn, step, mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    fails++;
                    $display("FAIL %s step%0d actual ns=%b ew=%b walk=%b ped=%b required ns=%b ew=%b walk=%b ped=%b",
                             scn, step, mon_a[7:5], mon_a[4:2], mon_a[1], mon_a[0],
                             mon_e[7:5], mon_e[4:2], mon_e[1], mon_e[0]);
                end
            end
            step++;
        end
    end

    task automatic ph(input logic [2:0] ns, input logic [2:0] ew, input logic w, input logic p, input int n);
        repeat (n) exp_q.push_back({ns, ew, w, p});
    endtask

    task automatic clr();
        for (int i = 0; i < 128; i++) begin
            btn_v[i] = 1'b0;
            rst_v[i] = 1'b0;
        end
        ph(R, R, 1'b0, 1'b0, 1);
    endtask

    // One reset cycle, then one design cycle per queued expectation.
    task automatic run(input string name);
        int n;
        n = exp_q.size() - 1;
        scn = name;
        step = 0;
        reset = 1'b0;
        button_state = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            reset = ~rst_v[c];
            button_state = btn_v[c];
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        button_state = 1'b0;
    endtask

    // Shared trace from NS yellow onward once a request was picked up in the first NS green.
    task automatic ped_tail();
        ph(Y, R, 1'b0, 1'b1, 3);
        ph(R, R, 1'b0, 1'b1, 2);
        ph(R, G, 1'b0, 1'b1, 4);
        ph(R, Y, 1'b0, 1'b1, 3);
        ph(R, R, 1'b0, 1'b1, 2);
        ph(R, R, 1'b1, 1'b0, 5);
        ph(G, R, 1'b0, 1'b0, 10);
        ph(Y, R, 1'b0, 1'b0, 3);
        ph(R, R, 1'b0, 1'b0, 2);
        ph(R, G, 1'b0, 1'b0, 10);
        ph(R, Y, 1'b0, 1'b0, 3);
        ph(R, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b0, 5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        button_state = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        clr();
        repeat (2) begin
            ph(R, R, 1'b0, 1'b0, 2);
            ph(G, R, 1'b0, 1'b0, 10);
            ph(Y, R, 1'b0, 1'b0, 3);
            ph(R, R, 1'b0, 1'b0, 2);
            ph(R, G, 1'b0, 1'b0, 10);
            ph(R, Y, 1'b0, 1'b0, 3);
        end
        run("idle");

        clr();
        btn_v[3] = 1'b1;
        btn_v[21] = 1'b1;
        ph(R, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b1, 2);
        ped_tail();
        run("pulse_then_walk_press");

        clr();
        for (int c = 2; c < 52; c++) btn_v[c] = 1'b1;
        ph(R, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b0, 1);
        ph(G, R, 1'b0, 1'b1, 3);
        ped_tail();
        run("held_button");

        clr();
        btn_v[1] = 1'b1;
        ph(R, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b1, 4);
        ped_tail();
        run("red2_last_cycle");

        clr();
        btn_v[0] = 1'b1;
        ph(R, R, 1'b0, 1'b0, 1);
        ph(R, R, 1'b0, 1'b1, 1);
        ph(R, R, 1'b1, 1'b0, 5);
        ph(G, R, 1'b0, 1'b0, 10);
        ph(Y, R, 1'b0, 1'b0, 3);
        run("first_cycle_press");

        clr();
        btn_v[20] = 1'b1;
        rst_v[22] = 1'b1;
        rst_v[23] = 1'b1;
        ph(R, R, 1'b0, 1'b0, 2);
        ph(G, R, 1'b0, 1'b0, 10);
        ph(Y, R, 1'b0, 1'b0, 3);
        ph(R, R, 1'b0, 1'b0, 2);
        ph(R, G, 1'b0, 1'b0, 4);
        ph(R, G, 1'b0, 1'b1, 1);
        ph(R, R, 1'b0, 1'b0, 4);
        ph(G, R, 1'b0, 1'b0, 5);
        run("reset_mid_ew_green");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter GREEN_CYC, default 10: green phase length in clk cycles.
REQ-002 Parameter YELLOW_CYC, default 3: yellow phase length in clk cycles.
REQ-003 Parameter ALLRED_CYC, default 2: all-red clearance length in clk cycles.
REQ-004 Parameter WALK_CYC, default 5: pedestrian walk length in clk cycles.
REQ-005 Parameter MIN_GREEN, default 4: minimum green cycles before a pending request shortens green; MIN_GREEN SHALL be ≤ GREEN_CYC.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 button_state  input  1  debounced pedestrian button level, synchronous to clk.
REQ-009 ns_light  output  3  north-south lamps {red,yellow,green}, one-hot.
REQ-010 ew_light  output  3  east-west lamps {red,yellow,green}, one-hot.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ped_pending  output  1  registered pedestrian request flag.

Function
REQ-013 States SHALL be RED2, NS_G, NS_Y, RED1, EW_G, EW_Y, WALK; ns_light/ew_light/walk SHALL be decoded from state alone (Moore).
REQ-014 Lamps: NS_G ns=001, ew=100; NS_Y ns=010, ew=100; EW_G ns=100, ew=001; EW_Y ns=100, ew=010; RED1/RED2/WALK ns=100, ew=100; walk=1 only in WALK.
REQ-015 A 16-bit down-counter SHALL load (phase length − 1) on the cycle the state is entered and decrement each cycle; the state advances on the cycle after the counter reads 0, so each phase lasts exactly its length in cycles.
REQ-016 A parameter value of 0 SHALL be treated as 1; values above 65535 are unsupported.
REQ-017 Sequence: RED2→NS_G→NS_Y→RED1→EW_G→EW_Y→RED2; from RED2 at expiry go to WALK if ped_pending=1, else to NS_G; WALK→NS_G at expiry.
REQ-018 A rising edge of button_state (current=1, previous-cycle register=0) SHALL set ped_pending on the next clk edge.
REQ-019 ped_pending SHALL clear on the clk edge that enters WALK; a set and a clear on the same edge SHALL resolve to clear.
REQ-020 Rising edges detected while in WALK SHALL be ignored; ped_pending stays 0 throughout WALK.
REQ-021 While ped_pending=1 in NS_G or EW_G, the green SHALL end after exactly MIN_GREEN cycles (or at normal expiry if already past MIN_GREEN) and proceed to yellow.
REQ-022 Transition decisions SHALL use the registered ped_pending, not the same-cycle edge; an edge on RED2's final cycle is therefore serviced on the next pass through RED2.
REQ-023 A held-high button SHALL generate exactly one request.

Reset
REQ-024 While reset=0, asynchronously: state=RED2, counter=ALLRED_CYC−1, ped_pending=0, edge register=0, ns_light=100, ew_light=100, walk=0.
REQ-025 After release, RED2 SHALL last ALLRED_CYC cycles, then NS_G.
REQ-026 Assertion mid-phase SHALL abort the phase immediately with no yellow; any pending request is lost.
REQ-027 button_state=1 on the first cycle after release SHALL count as a rising edge.

Verification (defaults)
REQ-028 Release reset, no press -> 2 all-red, NS green 10, NS yellow 3, all-red 2, EW green 10, EW yellow 3, all-red 2; 30-cycle period, walk never 1.
REQ-029 1-cycle pulse at NS_G cycle 1 -> ped_pending=1 next cycle; NS green lasts 4, EW green lasts 4; after RED2 walk=1 for 5 cycles with all red, ped_pending=0 on entry; then NS_G.
REQ-030 button_state held high 50 cycles from NS_G entry -> exactly one WALK phase in 60 cycles.
REQ-031 Pulse during WALK -> ped_pending stays 0; next cycle skips WALK (plain 30-cycle period).
REQ-032 Pulse on RED2's final cycle (no prior request) -> NS_G entered, ped_pending=1; that cycle's NS and EW greens shortened to 4; WALK on following RED2.
REQ-033 reset=0 at EW_G cycle 5 with ped_pending=1 -> same instant ns=100, ew=100, walk=0, ped_pending=0; after release 2 all-red cycles, then NS_G.
